// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU: sequences fetch/decode/execute/
// memory/writeback and drives the datapath mux selects and memory strobes.
module control_fsm #(
   parameter int OP_W = 4,
   parameter int FN_W = 4
) (
   input  logic            Clock,
   input  logic            Reset,
   input  logic [15:0]     Instr,
   input  logic            MemReady,
   input  logic            Zero,
   output logic            PCWrite,
   output logic [1:0]      PCSrc,
   output logic            IRWrite,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            RegWrite,
   output logic            ALUSrc,
   output logic            MemToReg,
   output logic            RegDst,
   output logic [FN_W-1:0] ALUOp,
   output logic            Illegal,
   output logic            Halted,
   output logic [2:0]      State
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
   localparam logic [OP_W-1:0] OP_ADDI = OP_W'(1);
   localparam logic [OP_W-1:0] OP_LW   = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SW   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_JMP  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);

   state_t            state_q, state_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [FN_W-1:0]   funct_q, funct_d;

   function automatic logic is_defined(input logic [OP_W-1:0] op);
      return (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
             (op == OP_SW) || (op == OP_BEQ) || (op == OP_JMP);
   endfunction

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         funct_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         funct_q <= funct_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      funct_d  = funct_q;
      PCWrite  = 1'b0;
      PCSrc    = 2'd0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      ALUSrc   = 1'b0;
      MemToReg = 1'b0;
      RegDst   = 1'b0;
      ALUOp    = '0;
      Illegal  = 1'b0;
      Halted   = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            if (MemReady) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               PCSrc   = 2'd0;
               op_d    = Instr[15 -: OP_W];
               funct_d = Instr[FN_W-1:0];
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (op_q == OP_HALT) begin
               state_d = S_HALT;
            end else if (!is_defined(op_q)) begin
               Illegal = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_q)
               OP_R: begin
                  ALUOp   = funct_q;
                  state_d = S_WB;
               end
               OP_ADDI: begin
                  ALUSrc  = 1'b1;
                  state_d = S_WB;
               end
               OP_LW, OP_SW: begin
                  ALUSrc  = 1'b1;
                  state_d = S_MEM;
               end
               OP_BEQ: begin
                  ALUOp = FN_W'(1);
                  if (Zero) begin
                     PCWrite = 1'b1;
                     PCSrc   = 2'd1;
                  end
                  state_d = S_FETCH;
               end
               OP_JMP: begin
                  PCWrite = 1'b1;
                  PCSrc   = 2'd2;
                  state_d = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            // Read and write are mutually exclusive because only one opcode can be latched.
            if (op_q == OP_LW) begin
               MemRead = 1'b1;
               ALUSrc  = 1'b1;
               if (MemReady) state_d = S_WB;
            end else if (op_q == OP_SW) begin
               MemWrite = 1'b1;
               ALUSrc   = 1'b1;
               if (MemReady) state_d = S_FETCH;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemToReg = (op_q == OP_LW);
            RegDst   = (op_q == OP_R);
            state_d  = S_FETCH;
         end
         S_HALT: Halted = 1'b1;
         default: state_d = S_FETCH;
      endcase

      // Reset silences every strobe in the same cycle it is asserted.
      if (Reset) begin
         PCWrite  = 1'b0;
         PCSrc    = 2'd0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         ALUSrc   = 1'b0;
         MemToReg = 1'b0;
         RegDst   = 1'b0;
         ALUOp    = '0;
         Illegal  = 1'b0;
         Halted   = 1'b0;
      end
   end

   assign State = Reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed-vector bench for control_fsm: each task walks an instruction through
// its states cycle by cycle and compares the full output vector.
module tb_control_fsm;

   logic        Clock;
   logic        Reset;
   logic [15:0] Instr;
   logic        MemReady;
   logic        Zero;
   logic        PCWrite;
   logic [1:0]  PCSrc;
   logic        IRWrite;
   logic        MemRead;
   logic        MemWrite;
   logic        RegWrite;
   logic        ALUSrc;
   logic        MemToReg;
   logic        RegDst;
   logic [3:0]  ALUOp;
   logic        Illegal;
   logic        Halted;
   logic [2:0]  State;

   int n_checks = 0;
   int n_fail   = 0;

   control_fsm #(.OP_W(4), .FN_W(4)) dut (
      .Clock(Clock), .Reset(Reset), .Instr(Instr), .MemReady(MemReady), .Zero(Zero),
      .PCWrite(PCWrite), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemRead(MemRead),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
      .RegDst(RegDst), .ALUOp(ALUOp), .Illegal(Illegal), .Halted(Halted), .State(State)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   logic [18:0] outs;
   assign outs = {PCWrite, PCSrc, IRWrite, MemRead, MemWrite, RegWrite, ALUSrc,
                  MemToReg, RegDst, ALUOp, Illegal, Halted, State};

   localparam logic [18:0] PCW  = 19'h40000;
   localparam logic [18:0] PCS1 = 19'h10000;
   localparam logic [18:0] PCS2 = 19'h20000;
   localparam logic [18:0] IRW  = 19'h08000;
   localparam logic [18:0] MR   = 19'h04000;
   localparam logic [18:0] MW   = 19'h02000;
   localparam logic [18:0] RW   = 19'h01000;
   localparam logic [18:0] AS   = 19'h00800;
   localparam logic [18:0] M2R  = 19'h00400;
   localparam logic [18:0] RD   = 19'h00200;
   localparam logic [18:0] AOP1 = 19'h00020;
   localparam logic [18:0] AOP3 = 19'h00060;
   localparam logic [18:0] ILL  = 19'h00010;
   localparam logic [18:0] HLT  = 19'h00008;
   localparam logic [18:0] FET  = PCW | IRW | MR;

   // Stimulus word: top hex digit = {Reset, MemReady, Zero}, low 16 bits = Instr.
   task automatic drive(input logic [18:0] s);
      @(negedge Clock);
      Reset    = s[18];
      MemReady = s[17];
      Zero     = s[16];
      Instr    = s[15:0];
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(19'h6_0123);
         n_checks++;
         if (outs !== 19'h0) begin
            n_fail++;
            $display("FAIL reset[%0d]: got %h expected %h", i, outs, 19'h0);
         end
      end
   endtask

   task automatic test_rtype();
      logic [18:0] sv [5] = '{19'h2_0123, 19'h2_0123, 19'h2_0123, 19'h0_0123, 19'h0_0123};
      logic [18:0] ex [5] = '{FET, 19'd1, AOP3 | 19'd2, RW | RD | 19'd4, MR};
      for (int i = 0; i < 5; i++) begin
         drive(sv[i]);
         n_checks++;
         if (outs !== ex[i]) begin
            n_fail++;
            $display("FAIL rtype[%0d]: got %h expected %h", i, outs, ex[i]);
         end
      end
   endtask

   task automatic test_lw_wait();
      // Instr changes to 0xFFFF after fetch; the latched LW must be unaffected.
      logic [18:0] sv [8] = '{19'h2_2105, 19'h2_FFFF, 19'h0_FFFF, 19'h0_FFFF,
                              19'h0_FFFF, 19'h2_FFFF, 19'h0_FFFF, 19'h0_FFFF};
      logic [18:0] ex [8] = '{FET, 19'd1, AS | 19'd2, MR | AS | 19'd3,
                              MR | AS | 19'd3, MR | AS | 19'd3, RW | M2R | 19'd4, MR};
      for (int i = 0; i < 8; i++) begin
         drive(sv[i]);
         n_checks++;
         if (outs !== ex[i]) begin
            n_fail++;
            $display("FAIL lw_wait[%0d]: got %h expected %h", i, outs, ex[i]);
         end
      end
   endtask

   task automatic test_beq(input logic z);
      logic [18:0] sv [4];
      logic [18:0] ex [4];
      sv = '{19'h2_4300, 19'h0_4300, {2'b00, z, 16'h4300}, 19'h0_4300};
      ex = '{FET, 19'd1, AOP1 | (z ? (PCW | PCS1) : 19'h0) | 19'd2, MR};
      for (int i = 0; i < 4; i++) begin
         drive(sv[i]);
         n_checks++;
         if (outs !== ex[i]) begin
            n_fail++;
            $display("FAIL beq_z%0d[%0d]: got %h expected %h", z, i, outs, ex[i]);
         end
      end
   endtask

   task automatic test_jmp();
      logic [18:0] sv [4] = '{19'h2_5000, 19'h0_5000, 19'h0_5000, 19'h0_5000};
      logic [18:0] ex [4] = '{FET, 19'd1, PCW | PCS2 | 19'd2, MR};
      for (int i = 0; i < 4; i++) begin
         drive(sv[i]);
         n_checks++;
         if (outs !== ex[i]) begin
            n_fail++;
            $display("FAIL jmp[%0d]: got %h expected %h", i, outs, ex[i]);
         end
      end
   endtask

   task automatic test_illegal();
      logic [18:0] sv [4] = '{19'h2_7000, 19'h0_7000, 19'h0_7000, 19'h1_7000};
      logic [18:0] ex [4] = '{FET, ILL | 19'd1, MR, MR};
      for (int i = 0; i < 4; i++) begin
         drive(sv[i]);
         n_checks++;
         if (outs !== ex[i]) begin
            n_fail++;
            $display("FAIL illegal[%0d]: got %h expected %h", i, outs, ex[i]);
         end
      end
   endtask

   task automatic test_reset_mid_sw();
      logic [18:0] sv [10] = '{19'h2_3105, 19'h0_3105, 19'h0_3105, 19'h0_3105, 19'h4_3105,
                               19'h2_1207, 19'h0_1207, 19'h0_1207, 19'h0_1207, 19'h0_1207};
      logic [18:0] ex [10] = '{FET, 19'd1, AS | 19'd2, MW | AS | 19'd3, 19'h0,
                               FET, 19'd1, AS | 19'd2, RW | 19'd4, MR};
      for (int i = 0; i < 10; i++) begin
         drive(sv[i]);
         n_checks++;
         if (outs !== ex[i]) begin
            n_fail++;
            $display("FAIL reset_sw[%0d]: got %h expected %h", i, outs, ex[i]);
         end
      end
   endtask

   task automatic test_halt();
      logic [18:0] sv [16];
      logic [18:0] ex [16];
      sv[0] = 19'h2_F000;  ex[0] = FET;
      sv[1] = 19'h0_F000;  ex[1] = 19'd1;
      for (int k = 2; k < 14; k++) begin
         sv[k] = (k % 2 == 0) ? 19'h3_0123 : 19'h2_2105;
         ex[k] = HLT | 19'd5;
      end
      sv[14] = 19'h6_0000; ex[14] = 19'h0;
      sv[15] = 19'h0_0000; ex[15] = MR;
      for (int i = 0; i < 16; i++) begin
         drive(sv[i]);
         n_checks++;
         if (outs !== ex[i]) begin
            n_fail++;
            $display("FAIL halt[%0d]: got %h expected %h", i, outs, ex[i]);
         end
      end
   endtask

   initial begin
      Reset    = 1'b1;
      MemReady = 1'b1;
      Zero     = 1'b0;
      Instr    = 16'h0123;
      test_reset();
      test_rtype();
      test_lw_wait();
      test_beq(1'b1);
      test_beq(1'b0);
      test_jmp();
      test_illegal();
      test_reset_mid_sw();
      test_halt();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
